// File: rtl/square_motion_sched.sv
// Frame-rate scheduler for N bouncing squares sharing one add/sub/compare unit (X then Y per square).
// Start in cycle t gives done in t+2N+1; config writes are accepted only while idle, and start while busy only flags overrun.
module square_motion_sched #(
  parameter int N     = 3,
  parameter int CORDW = 12,
  parameter int H_RES = 1920,
  parameter int V_RES = 1080
) (
  input  logic               clk_pix,
  input  logic               rst,
  input  logic               start,
  input  logic               cfg_we,
  input  logic [2:0]         cfg_id,
  input  logic               cfg_en,
  input  logic [CORDW-1:0]   cfg_size,
  input  logic [CORDW-1:0]   cfg_speed,
  input  logic [CORDW-1:0]   cfg_x,
  input  logic [CORDW-1:0]   cfg_y,
  output logic               cfg_ready,
  output logic               busy,
  output logic               done,
  output logic               overrun,
  output logic [N*CORDW-1:0] pos_x,
  output logic [N*CORDW-1:0] pos_y,
  output logic [N-1:0]       dir_x,
  output logic [N-1:0]       dir_y
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int AW = CORDW + 2;
  localparam logic signed [AW-1:0] RES_H = AW'(H_RES);
  localparam logic signed [AW-1:0] RES_V = AW'(V_RES);
  localparam logic signed [AW-1:0] PMAX  = AW'((1 << CORDW) - 1);

  typedef enum logic [1:0] {IDLE, UPD_X, UPD_Y, COMMIT} state_t;

  state_t             r_state;
  logic [IW-1:0]      r_idx;
  logic               r_busy;
  logic               r_done;
  logic [CORDW-1:0]   r_wx    [N];
  logic [CORDW-1:0]   r_wy    [N];
  logic [CORDW-1:0]   r_size  [N];
  logic [CORDW-1:0]   r_speed [N];
  logic [N-1:0]       r_wdx;
  logic [N-1:0]       r_wdy;
  logic [N-1:0]       r_en;
  logic [N*CORDW-1:0] r_pos_x;
  logic [N*CORDW-1:0] r_pos_y;
  logic [N-1:0]       r_dir_x;
  logic [N-1:0]       r_dir_y;

  logic               w_cfg_acc;
  logic [IW-1:0]      w_cfg_idx;

  assign w_cfg_acc = cfg_we && !r_busy && ({1'b0, cfg_id} < 4'(N));
  assign w_cfg_idx = cfg_id[IW-1:0];

  // Shared axis unit: the FSM state selects which axis of square r_idx is evaluated.
  logic                    w_axis_y;
  logic signed [AW-1:0]    w_p, w_s, w_z, w_r, w_thr, w_sub, w_add;
  logic                    w_dir, w_new_dir;
  logic [CORDW-1:0]        w_sub_sat, w_add_sat, w_new_p;

  always_comb begin
    w_axis_y  = (r_state == UPD_Y);
    w_p       = {2'b00, (w_axis_y ? r_wy[r_idx] : r_wx[r_idx])};
    w_dir     = w_axis_y ? r_wdy[r_idx] : r_wdx[r_idx];
    w_s       = {2'b00, r_speed[r_idx]};
    w_z       = {2'b00, r_size[r_idx]};
    w_r       = w_axis_y ? RES_V : RES_H;
    w_thr     = w_r - (w_z + w_s);
    w_sub     = w_p - w_s;
    w_add     = w_p + w_s;
    w_sub_sat = (w_sub < 0) ? '0 : w_sub[CORDW-1:0];
    w_add_sat = (w_add > PMAX) ? '1 : w_add[CORDW-1:0];
    w_new_dir = w_dir;
    w_new_p   = w_dir ? w_sub_sat : w_add_sat;
    if (w_p >= w_thr) begin
      w_new_dir = 1'b1;
      w_new_p   = w_sub_sat;
    end else if (w_p < w_s) begin
      w_new_dir = 1'b0;
      w_new_p   = w_add_sat;
    end
  end

  always_ff @(posedge clk_pix) begin
    if (rst) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_wdx   <= '0;
      r_wdy   <= '0;
      r_en    <= '0;
      r_pos_x <= '0;
      r_pos_y <= '0;
      r_dir_x <= '0;
      r_dir_y <= '0;
      for (int i = 0; i < N; i++) begin
        r_wx[i]    <= '0;
        r_wy[i]    <= '0;
        r_size[i]  <= '0;
        r_speed[i] <= '0;
      end
    end else begin
      r_done <= 1'b0;
      // A write lands in the same edge that may launch a sequence, so the sequence sees it.
      if (w_cfg_acc) begin
        r_wx[w_cfg_idx]    <= cfg_x;
        r_wy[w_cfg_idx]    <= cfg_y;
        r_size[w_cfg_idx]  <= cfg_size;
        r_speed[w_cfg_idx] <= cfg_speed;
        r_en[w_cfg_idx]    <= cfg_en;
        r_wdx[w_cfg_idx]   <= 1'b0;
        r_wdy[w_cfg_idx]   <= 1'b0;
        r_pos_x[w_cfg_idx*CORDW +: CORDW] <= cfg_x;
        r_pos_y[w_cfg_idx*CORDW +: CORDW] <= cfg_y;
        r_dir_x[w_cfg_idx] <= 1'b0;
        r_dir_y[w_cfg_idx] <= 1'b0;
      end
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state <= UPD_X;
            r_idx   <= '0;
            r_busy  <= 1'b1;
          end
        end
        UPD_X: begin
          if (r_en[r_idx]) begin
            r_wx[r_idx]  <= w_new_p;
            r_wdx[r_idx] <= w_new_dir;
          end
          r_state <= UPD_Y;
        end
        UPD_Y: begin
          if (r_en[r_idx]) begin
            r_wy[r_idx]  <= w_new_p;
            r_wdy[r_idx] <= w_new_dir;
          end
          if (r_idx == IW'(N - 1)) begin
            r_state <= COMMIT;
            r_done  <= 1'b1;
          end else begin
            r_idx   <= r_idx + IW'(1);
            r_state <= UPD_X;
          end
        end
        COMMIT: begin
          for (int i = 0; i < N; i++) begin
            r_pos_x[i*CORDW +: CORDW] <= r_wx[i];
            r_pos_y[i*CORDW +: CORDW] <= r_wy[i];
          end
          r_dir_x <= r_wdx;
          r_dir_y <= r_wdy;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy      = r_busy;
  assign cfg_ready = !r_busy;
  assign done      = r_done;
  assign overrun   = start && r_busy;
  assign pos_x     = r_pos_x;
  assign pos_y     = r_pos_y;
  assign dir_x     = r_dir_x;
  assign dir_y     = r_dir_y;
endmodule
